lfsr_step_ctrl: RTL and testbench

LFSR_STEP_CTRL -- requirements
Module: lfsr_step_ctrl

---
 rtl/lfsr_step_ctrl_pkg.sv | 15 +
 rtl/lfsr_step_ctrl_btn_debounce.sv | 45 ++++
 rtl/lfsr_step_ctrl.sv | 77 +++++++
 tb/tb_lfsr_step_ctrl.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_step_ctrl_pkg.sv
// Board constants shared by the LFSR, step control and seven-segment blocks.
// Holds the debounce/auto-run defaults and the step counter width.
package lfsr_step_ctrl_pkg;

  localparam int DEB_CYCLES_DEF = 16;
  localparam int AUTO_DIV_DEF   = 1000;
  localparam int STEP_CNT_W     = 8;

  // Counter widths sized for the top of each parameter's legal range.
  localparam int DEB_CNT_W  = 16;
  localparam int AUTO_CNT_W = 24;

  typedef logic [STEP_CNT_W-1:0] step_cnt_t;

endpackage

// File: rtl/lfsr_step_ctrl_btn_debounce.sv
// Button synchronizer + debounce: 2-flop sync, level accepted after DEB_CYCLES stable cycles; rise is a 1-cycle pulse.
// Latency: stable/rise change DEB_CYCLES+2 edges after btn is first sampled; no backpressure.
module btn_debounce
  import lfsr_step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF
) (
  input  logic Clk,
  input  logic rst,
  input  logic btn,
  output logic stable,
  output logic rise
);

  localparam logic [DEB_CNT_W-1:0] DEB_LAST = DEB_CNT_W'(DEB_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  logic [DEB_CNT_W-1:0] cnt;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      stable <= 1'b0;
      rise   <= 1'b0;
      cnt    <= '0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      rise  <= 1'b0;
      if (sync2 == stable) begin
        cnt <= '0;
      end else if (cnt == DEB_LAST) begin
        // Accept the new level on the edge the count would reach DEB_CYCLES.
        cnt    <= '0;
        stable <= ~stable;
        rise   <= ~stable;
      end else begin
        cnt <= cnt + DEB_CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/lfsr_step_ctrl.sv
// LFSR step control: debounced single-step or (with LFSR_STEP_AUTO_EN) free-running step pulses, plus a step counter.
// Latency: press to step DEB_CYCLES+3 edges, auto step every AUTO_DIV cycles; no backpressure, step never high twice in a row.
module lfsr_step_ctrl
  import lfsr_step_ctrl_pkg::*;
#(
  parameter int DEB_CYCLES = DEB_CYCLES_DEF,
  parameter int AUTO_DIV   = AUTO_DIV_DEF
) (
  input  logic                  Clk,
  input  logic                  rst,
  input  logic                  btn,
  input  logic                  auto_run,
  output logic                  step,
  output logic [STEP_CNT_W-1:0] step_cnt
);

  localparam logic [AUTO_CNT_W-1:0] AUTO_LAST = AUTO_CNT_W'(AUTO_DIV - 1);

  logic deb_stable;
  logic deb_rise;
  logic step_nxt;
  logic unused_sig;

  btn_debounce #(
    .DEB_CYCLES(DEB_CYCLES)
  ) u_btn_debounce (
    .Clk   (Clk),
    .rst   (rst),
    .btn   (btn),
    .stable(deb_stable),
    .rise  (deb_rise)
  );

`ifdef LFSR_STEP_AUTO_EN
  logic [AUTO_CNT_W-1:0] presc;
  logic                  presc_wrap;

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      presc <= '0;
    end else if (!auto_run) begin
      presc <= '0;
    end else if (presc == AUTO_LAST) begin
      presc <= '0;
    end else begin
      presc <= presc + AUTO_CNT_W'(1);
    end
  end

  assign presc_wrap = auto_run && (presc == AUTO_LAST);
  assign unused_sig = deb_stable;

  // Presses debounced during auto-run are dropped, not queued.
  always_comb begin
    step_nxt = auto_run ? presc_wrap : deb_rise;
    if (step) step_nxt = 1'b0;
  end
`else
  assign unused_sig = deb_stable ^ auto_run ^ AUTO_LAST[0];

  always_comb begin
    step_nxt = deb_rise;
    if (step) step_nxt = 1'b0;
  end
`endif

  always_ff @(posedge Clk or negedge rst) begin
    if (!rst) begin
      step     <= 1'b0;
      step_cnt <= '0;
    end else begin
      step     <= step_nxt;
      step_cnt <= step_cnt + STEP_CNT_W'(step_nxt);
    end
  end

endmodule

// File: tb/tb_lfsr_step_ctrl.sv
// Self-checking bench for lfsr_step_ctrl with DEB_CYCLES=4, AUTO_DIV=5.
// Reference model works on sampled button history and pulse counting.
module tb_lfsr_step_ctrl;

  localparam int DEB  = 4;
  localparam int ADIV = 5;

  logic       Clk      = 1'b0;
  logic       rst      = 1'b0;
  logic       btn      = 1'b0;
  logic       auto_run = 1'b0;
  logic       step;
  logic [7:0] step_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 Clk = ~Clk;

  lfsr_step_ctrl #(
    .DEB_CYCLES(DEB),
    .AUTO_DIV  (ADIV)
  ) dut (
    .Clk     (Clk),
    .rst     (rst),
    .btn     (btn),
    .auto_run(auto_run),
    .step    (step),
    .step_cnt(step_cnt)
  );

  // Reference model: the level seen by the debouncer is btn as sampled two
  // edges earlier; the accepted level flips once the last DEB seen levels
  // all differ from it. Auto mode pulses on every ADIV-th consecutive high edge.
  bit       m_b1, m_b2, m_stable, m_rise, m_step;
  bit [7:0] m_cnt;
  int       m_auto_len;
  bit       lvl_q[$];
  bit       m_lvl, m_next, m_up, m_all_diff;

  always @(posedge Clk or negedge rst) begin
    if (!rst) begin
      m_b1 = 0; m_b2 = 0; m_stable = 0; m_rise = 0; m_step = 0;
      m_cnt = 0; m_auto_len = 0;
      lvl_q.delete();
    end else begin
      m_lvl = m_b2;
      m_b2  = m_b1;
      m_b1  = btn;
`ifdef LFSR_STEP_AUTO_EN
      if (auto_run) begin
        m_auto_len = m_auto_len + 1;
        m_next = ((m_auto_len % ADIV) == 0);
      end else begin
        m_auto_len = 0;
        m_next = m_rise;
      end
`else
      m_next = m_rise;
`endif
      if (m_step) m_next = 0;
      lvl_q.push_back(m_lvl);
      if (lvl_q.size() > DEB) void'(lvl_q.pop_front());
      m_up = 0;
      if (lvl_q.size() == DEB) begin
        m_all_diff = 1;
        foreach (lvl_q[i]) if (lvl_q[i] == m_stable) m_all_diff = 0;
        if (m_all_diff) begin
          m_stable = !m_stable;
          m_up = m_stable;
          lvl_q.delete();
        end
      end
      m_rise = m_up;
      m_step = m_next;
      m_cnt  = m_cnt + 8'(m_next);
    end
  end

  task automatic do_reset();
    @(negedge Clk);
    rst = 1'b0;
    @(negedge Clk);
    @(negedge Clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0; btn = 1'b1; auto_run = 1'b0;
    @(negedge Clk);
    n_cmp++;
    if (step !== 1'b0) begin n_bad++; $display("FAIL reset_step: got %0b want 0", step); end
    n_cmp++;
    if (step_cnt !== 8'd0) begin n_bad++; $display("FAIL reset_cnt: got %0d want 0", step_cnt); end
    btn = 1'b0;
    rst = 1'b1;
    for (int k = 0; k < 8; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (step !== 1'b0) begin n_bad++; $display("FAIL reset_idle: got %0b want 0 at %0d", step, k); end
    end
  endtask

  task automatic test_clean_press();
    do_reset();
    btn = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (step !== (k == 7)) begin n_bad++; $display("FAIL press_latency: edge %0d step=%0b want %0b", k, step, (k == 7)); end
      n_cmp++;
      if (step !== m_step || step_cnt !== m_cnt) begin
        n_bad++; $display("FAIL press_model: edge %0d step=%0b cnt=%0d want %0b/%0d", k, step, step_cnt, m_step, m_cnt);
      end
    end
    btn = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (step !== 1'b0) begin n_bad++; $display("FAIL release_pulse: cycle %0d step=%0b want 0", k, step); end
    end
    n_cmp++;
    if (step_cnt !== 8'd1) begin n_bad++; $display("FAIL press_cnt: got %0d want 1", step_cnt); end
  endtask

  task automatic test_bounce();
    do_reset();
    for (int k = 0; k < 30; k++) begin
      btn = ((k / 2) % 2 == 0);
      @(negedge Clk);
      n_cmp++;
      if (step !== 1'b0 || step !== m_step) begin n_bad++; $display("FAIL bounce_step: cycle %0d step=%0b want 0", k, step); end
    end
    btn = 1'b0;
    for (int k = 0; k < 12; k++) @(negedge Clk);
    n_cmp++;
    if (step_cnt !== 8'd0) begin n_bad++; $display("FAIL bounce_cnt: got %0d want 0", step_cnt); end
  endtask

`ifdef LFSR_STEP_AUTO_EN
  task automatic test_auto();
    do_reset();
    auto_run = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      btn = (k >= 3 && k < 15);
      @(negedge Clk);
      n_cmp++;
      if (step !== ((k % ADIV) == 0)) begin n_bad++; $display("FAIL auto_step: edge %0d step=%0b want %0b", k, step, ((k % ADIV) == 0)); end
      n_cmp++;
      if (step_cnt !== m_cnt) begin n_bad++; $display("FAIL auto_model_cnt: edge %0d got %0d want %0d", k, step_cnt, m_cnt); end
    end
    auto_run = 1'b0;
    btn = 1'b0;
    for (int k = 0; k < 15; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (step !== 1'b0) begin n_bad++; $display("FAIL auto_after: cycle %0d step=%0b want 0", k, step); end
    end
    n_cmp++;
    if (step_cnt !== 8'd5) begin n_bad++; $display("FAIL auto_cnt: got %0d want 5", step_cnt); end
  endtask
`else
  task automatic test_macro_off();
    int pulses;
    do_reset();
    auto_run = 1'b1;
    pulses = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (step !== 1'b0) begin n_bad++; $display("FAIL noauto_idle: cycle %0d step=%0b want 0", k, step); end
    end
    btn = 1'b1;
    for (int k = 0; k < 24; k++) begin
      if (k == 12) btn = 1'b0;
      @(negedge Clk);
      if (step === 1'b1) pulses++;
    end
    auto_run = 1'b0;
    n_cmp++;
    if (pulses != 1) begin n_bad++; $display("FAIL noauto_press: pulses %0d want 1", pulses); end
    n_cmp++;
    if (step_cnt !== 8'd1) begin n_bad++; $display("FAIL noauto_cnt: got %0d want 1", step_cnt); end
  endtask
`endif

  task automatic test_mid_reset();
    do_reset();
    btn = 1'b1;
    for (int k = 0; k < 10; k++) @(negedge Clk);
    btn = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge Clk);
    btn = 1'b1;
    for (int k = 0; k < 4; k++) @(negedge Clk);
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (step !== 1'b0 || step_cnt !== 8'd0) begin
      n_bad++; $display("FAIL midrst_async: step=%0b cnt=%0d want 0/0", step, step_cnt);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (step !== 1'b0) begin n_bad++; $display("FAIL midrst_hold: step=%0b want 0", step); end
    end
    rst = 1'b1;
    for (int k = 1; k <= 14; k++) begin
      @(negedge Clk);
      n_cmp++;
      if (step !== (k == DEB + 3)) begin n_bad++; $display("FAIL midrst_pulse: edge %0d step=%0b want %0b", k, step, (k == DEB + 3)); end
    end
    n_cmp++;
    if (step_cnt !== 8'd1) begin n_bad++; $display("FAIL midrst_cnt: got %0d want 1", step_cnt); end
    btn = 1'b0;
    for (int k = 0; k < 10; k++) @(negedge Clk);
  endtask

  task automatic test_wrap();
    int pulses;
    int len;
    do_reset();
    pulses = 0;
    for (int p = 0; p < 256; p++) begin
      for (int ph = 0; ph < 2; ph++) begin
        btn = (ph == 0);
        len = $urandom_range(DEB + 6, DEB + 1);
        for (int k = 0; k < len; k++) begin
          @(negedge Clk);
          if (step === 1'b1) pulses++;
          n_cmp++;
          if (step !== m_step || step_cnt !== m_cnt) begin
            n_bad++; $display("FAIL wrap_model: press %0d step=%0b cnt=%0d want %0b/%0d", p, step, step_cnt, m_step, m_cnt);
          end
        end
      end
    end
    n_cmp++;
    if (pulses != 256) begin n_bad++; $display("FAIL wrap_pulses: got %0d want 256", pulses); end
    n_cmp++;
    if (step_cnt !== 8'd0) begin n_bad++; $display("FAIL wrap_cnt: got %0d want 0", step_cnt); end
  endtask

  task automatic test_random();
    int run;
    logic prev;
    do_reset();
    prev = 1'b0;
    run = 0;
    for (int k = 0; k < 800; k++) begin
      if (run == 0) begin
        btn = $urandom_range(1, 0);
        run = $urandom_range(9, 1);
      end
      run--;
      if ($urandom_range(59, 0) == 0) auto_run = ~auto_run;
      @(negedge Clk);
      n_cmp++;
      if (step !== m_step || step_cnt !== m_cnt) begin
        n_bad++; $display("FAIL random_model: cycle %0d step=%0b cnt=%0d want %0b/%0d", k, step, step_cnt, m_step, m_cnt);
      end
      n_cmp++;
      if (step === 1'b1 && prev === 1'b1) begin n_bad++; $display("FAIL random_b2b: cycle %0d step=1 twice, want gap", k); end
      prev = step;
    end
    auto_run = 1'b0;
    btn = 1'b0;
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
`ifdef LFSR_STEP_AUTO_EN
    test_auto();
`else
    test_macro_off();
`endif
    test_mid_reset();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
